// File: rtl/mem_copy_engine.sv
// Word-by-word memory copy/fill engine: copy takes 2*len+1 cycles start-to-done, fill len+1, len=0 takes 1.
// No backpressure: the memory is assumed to accept every access in one cycle; start is ignored while a transfer runs.
module mem_copy_engine #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              mode,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [3:0]        len,
   input  logic [DATA_W-1:0] fill_data,
   output logic              busy,
   output logic              done,
   output logic [3:0]        words_done,
   output logic [ADDR_W-1:0] mem_access_addr,
   output logic [DATA_W-1:0] mem_write_data,
   output logic              mem_write_en,
   output logic              mem_read,
   input  logic [DATA_W-1:0] mem_read_data
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_t            state;
   logic              mode_q;
   logic [ADDR_W-1:0] src_q;
   logic [ADDR_W-1:0] dst_q;
   logic [3:0]        rem_q;
   logic [DATA_W-1:0] fill_q;

   // Outputs are registered alongside the state; mem_write_data doubles as the word buffer in copy mode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         mode_q          <= 1'b0;
         src_q           <= '0;
         dst_q           <= '0;
         rem_q           <= '0;
         fill_q          <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         words_done      <= '0;
         mem_access_addr <= '0;
         mem_write_data  <= '0;
         mem_write_en    <= 1'b0;
         mem_read        <= 1'b0;
      end else begin
         busy            <= 1'b0;
         done            <= 1'b0;
         mem_access_addr <= '0;
         mem_write_data  <= '0;
         mem_write_en    <= 1'b0;
         mem_read        <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  mode_q     <= mode;
                  src_q      <= src_addr;
                  dst_q      <= dst_addr;
                  rem_q      <= len;
                  fill_q     <= fill_data;
                  words_done <= '0;
                  if (len == 4'd0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else if (mode) begin
                     state           <= WRITE;
                     busy            <= 1'b1;
                     mem_write_en    <= 1'b1;
                     mem_access_addr <= dst_addr;
                     mem_write_data  <= fill_data;
                  end else begin
                     state           <= READ;
                     busy            <= 1'b1;
                     mem_read        <= 1'b1;
                     mem_access_addr <= src_addr;
                  end
               end
            end
            READ: begin
               state           <= WRITE;
               busy            <= 1'b1;
               mem_write_en    <= 1'b1;
               mem_access_addr <= dst_q;
               mem_write_data  <= mem_read_data;
            end
            WRITE: begin
               src_q      <= src_q + ADDR_ONE;
               dst_q      <= dst_q + ADDR_ONE;
               words_done <= words_done + 4'd1;
               rem_q      <= rem_q - 4'd1;
               if (rem_q == 4'd1) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else if (mode_q) begin
                  state           <= WRITE;
                  busy            <= 1'b1;
                  mem_write_en    <= 1'b1;
                  mem_access_addr <= dst_q + ADDR_ONE;
                  mem_write_data  <= fill_q;
               end else begin
                  state           <= READ;
                  busy            <= 1'b1;
                  mem_read        <= 1'b1;
                  mem_access_addr <= src_q + ADDR_ONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine with a behavioural single-port memory.
module tb_mem_copy_engine;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        mode = 1'b0;
   logic [15:0] src_addr = '0;
   logic [15:0] dst_addr = '0;
   logic [3:0]  len = '0;
   logic [15:0] fill_data = '0;
   logic        busy, done, mem_write_en, mem_read;
   logic [3:0]  words_done;
   logic [15:0] mem_access_addr, mem_write_data, mem_read_data;

   logic [15:0] mem [0:65535];
   logic        pl_en = 1'b0;
   logic [15:0] pl_addr = '0;
   logic [15:0] pl_dat = '0;

   int n_run = 0;
   int n_fail = 0;
   int wr_cnt = 0;
   int rd_cnt = 0;
   int done_cnt = 0;
   int both_cnt = 0;

   always #5 clk = ~clk;

   mem_copy_engine #(.ADDR_W(16), .DATA_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
      .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_data(fill_data),
      .busy(busy), .done(done), .words_done(words_done),
      .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
      .mem_write_en(mem_write_en), .mem_read(mem_read), .mem_read_data(mem_read_data)
   );

   assign mem_read_data = mem[mem_access_addr];

   always @(posedge clk) begin
      if (mem_write_en) mem[mem_access_addr] <= mem_write_data;
      else if (pl_en)   mem[pl_addr] <= pl_dat;
      if (mem_write_en) wr_cnt <= wr_cnt + 1;
      if (mem_read)     rd_cnt <= rd_cnt + 1;
      if (done)         done_cnt <= done_cnt + 1;
      if (mem_read && mem_write_en) both_cnt <= both_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic preload(input logic [15:0] a, input logic [15:0] d);
      @(negedge clk);
      pl_en = 1'b1; pl_addr = a; pl_dat = d;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   // Launches a transfer and checks done latency (cycle 1 = first cycle after the start edge),
   // busy during the transfer, strobe counts and the final word count.
   task automatic run(input string tag, input logic m, input logic [15:0] s, input logic [15:0] d,
                      input logic [3:0] l, input logic [15:0] f, input int exp_cyc,
                      input int exp_rd, input int exp_wr, input logic hold_start);
      int wr0, rd0, dn0, got_cyc;
      @(negedge clk);
      start = 1'b1; mode = m; src_addr = s; dst_addr = d; len = l; fill_data = f;
      wr0 = wr_cnt; rd0 = rd_cnt; dn0 = done_cnt; got_cyc = 0;
      @(posedge clk); #1;
      if (!hold_start) start = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         if (c == 1 && l != 4'd0) check({tag, "_busy"}, busy, 1'b1);
         if (done) begin got_cyc = c; break; end
         @(posedge clk); #1;
      end
      start = 1'b0;
      check({tag, "_done_cyc"}, got_cyc, exp_cyc);
      check({tag, "_busy_in_done"}, busy, 1'b0);
      check({tag, "_words"}, words_done, l);
      @(posedge clk); #1;
      check({tag, "_done_pulse"}, done, 1'b0);
      check({tag, "_n_done"}, done_cnt - dn0, 1);
      check({tag, "_n_rd"}, rd_cnt - rd0, exp_rd);
      check({tag, "_n_wr"}, wr_cnt - wr0, exp_wr);
   endtask

   initial begin
      #2;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_we_rd", {mem_write_en, mem_read}, 2'b00);
      check("rst_words", words_done, 4'd0);
      check("rst_addr_data", {mem_access_addr, mem_write_data}, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      // Plain copy
      preload(16'd0, 16'h1111); preload(16'd1, 16'h2222); preload(16'd2, 16'h3333);
      run("copy3", 1'b0, 16'd0, 16'd4, 4'd3, 16'h0, 7, 3, 3, 1'b0);
      check("copy3_m4", mem[4], 16'h1111);
      check("copy3_m5", mem[5], 16'h2222);
      check("copy3_m6", mem[6], 16'h3333);
      repeat (3) @(posedge clk); #1;
      check("copy3_words_hold", words_done, 4'd3);
      check("idle_addr_data", {mem_access_addr, mem_write_data}, 32'h0);

      // Fill
      run("fill4", 1'b1, 16'h0, 16'd2, 4'd4, 16'hA5A5, 5, 0, 4, 1'b0);
      for (int i = 2; i <= 5; i++) check("fill4_mem", mem[i], 16'hA5A5);
      check("fill4_m6_untouched", mem[6], 16'h3333);

      // Zero length
      run("len0", 1'b0, 16'd0, 16'd8, 4'd0, 16'h0, 1, 0, 0, 1'b0);

      // Overlapping forward copy propagates the first word
      preload(16'd0, 16'h0001); preload(16'd1, 16'h0BAD);
      preload(16'd2, 16'h0BAD); preload(16'd3, 16'h0BAD);
      run("ovl", 1'b0, 16'd0, 16'd1, 4'd3, 16'h0, 7, 3, 3, 1'b0);
      for (int i = 1; i <= 3; i++) check("ovl_mem", mem[i], 16'h0001);

      // Destination wrap
      preload(16'h0010, 16'hBEEF); preload(16'h0011, 16'hCAFE);
      run("wrap", 1'b0, 16'h0010, 16'hFFFF, 4'd2, 16'h0, 5, 2, 2, 1'b0);
      check("wrap_mffff", mem[16'hFFFF], 16'hBEEF);
      check("wrap_m0000", mem[0], 16'hCAFE);

      // start held high throughout: one transfer only
      preload(16'h0050, 16'h5050); preload(16'h0051, 16'h5151); preload(16'h0052, 16'h5252);
      run("hold", 1'b0, 16'h0050, 16'h0060, 4'd3, 16'h0, 7, 3, 3, 1'b1);
      check("hold_idle_busy", busy, 1'b0);
      check("hold_m62", mem[16'h0062], 16'h5252);
      run("after_hold", 1'b1, 16'h0, 16'h0070, 4'd1, 16'h7777, 2, 0, 1, 1'b0);
      check("after_hold_m70", mem[16'h0070], 16'h7777);

      // Reset during the second WRITE of a len=4 copy
      preload(16'h0020, 16'hAAA0); preload(16'h0021, 16'hAAA1);
      preload(16'h0022, 16'hAAA2); preload(16'h0023, 16'hAAA3);
      preload(16'h0030, 16'h0000); preload(16'h0031, 16'h0000);
      begin
         int dn0;
         dn0 = done_cnt;
         @(negedge clk);
         start = 1'b1; mode = 1'b0; src_addr = 16'h0020; dst_addr = 16'h0030; len = 4'd4;
         @(posedge clk); #1;
         start = 1'b0;
         repeat (3) begin @(posedge clk); #1; end
         check("rst_mid_we_before", mem_write_en, 1'b1);
         rst_n = 1'b0;
         #1;
         check("rst_mid_we", mem_write_en, 1'b0);
         check("rst_mid_rd", mem_read, 1'b0);
         check("rst_mid_busy_words", {busy, words_done}, 5'd0);
         repeat (3) @(posedge clk);
         #1;
         check("rst_mid_no_done", done_cnt - dn0, 0);
         check("rst_mid_m30", mem[16'h0030], 16'hAAA0);
         check("rst_mid_m31", mem[16'h0031], 16'h0000);
         @(negedge clk) rst_n = 1'b1;
      end
      run("post_rst", 1'b0, 16'h0022, 16'h0040, 4'd1, 16'h0, 3, 1, 1, 1'b0);
      check("post_rst_m40", mem[16'h0040], 16'hAAA2);

      check("rd_we_exclusive", both_cnt, 0);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 Parameter: ADDR_W, 16, width of memory address bus.
REQ-002 Parameter: DATA_W, 16, width of memory data word.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request a transfer; sampled only in IDLE.
REQ-006 mode  input  1  0 = copy src->dst, 1 = fill dst with fill_data.
REQ-007 src_addr  input  ADDR_W  first source word address (copy only).
REQ-008 dst_addr  input  ADDR_W  first destination word address.
REQ-009 len  input  4  number of words to transfer, 0..15.
REQ-010 fill_data  input  DATA_W  pattern written in fill mode.
REQ-011 busy  output  1  high while a transfer is in progress (READ/WRITE states).
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 words_done  output  4  count of words written in the current/last transfer.
REQ-014 mem_access_addr  output  ADDR_W  address to data memory, shared read/write.
REQ-015 mem_write_data  output  DATA_W  write data to data memory.
REQ-016 mem_write_en  output  1  write strobe; memory writes on the rising edge while high.
REQ-017 mem_read  output  1  read enable; memory returns data combinationally.
REQ-018 mem_read_data  input  DATA_W  read data from data memory, valid in the same cycle as mem_read.

Function
REQ-019 The FSM SHALL have states IDLE, READ, WRITE, DONE.
REQ-020 In IDLE with start=1 at a rising edge, the block SHALL latch mode, src_addr, dst_addr, len, fill_data into internal registers, clear words_done, and go to DONE if len=0, else READ (mode 0) or WRITE (mode 1).
REQ-021 start SHALL be ignored in READ, WRITE and DONE; latched parameters SHALL not change mid-transfer.
REQ-022 READ: mem_read=1, mem_access_addr=src pointer; at the edge, mem_read_data SHALL be captured into a word buffer; next state WRITE.
REQ-023 WRITE: mem_write_en=1, mem_access_addr=dst pointer, mem_write_data=buffer (copy) or latched fill_data (fill).
REQ-024 At the WRITE edge: src and dst pointers SHALL increment by 1 modulo 2^ADDR_W, words_done SHALL increment, remaining count SHALL decrement; next state DONE if the last word was written, else READ (copy) or WRITE (fill).
REQ-025 DONE: done=1 for exactly one cycle, busy=0; next state IDLE unconditionally.
REQ-026 All memory-side outputs and busy/done SHALL be decoded from registered state only, with no combinational path from start or other inputs.
REQ-027 mem_read and mem_write_en SHALL never be high in the same cycle; outside READ, mem_read=0; outside WRITE, mem_write_en=0.
REQ-028 In IDLE and DONE, mem_access_addr and mem_write_data SHALL be 0.
REQ-029 Latency: done SHALL assert 2*len+1 cycles after the start-sampling edge in copy mode, len+1 in fill mode, and 1 cycle for len=0.
REQ-030 Overlapping copy ranges SHALL have strictly sequential forward word-by-word semantics (each read sees all earlier writes).
REQ-031 Address wrap at 0xFFFF->0x0000 SHALL be silent and continue the transfer.
REQ-032 words_done SHALL hold its final value after DONE until the next accepted start.

Reset
REQ-033 While rst_n=0, state SHALL be IDLE and busy, done, mem_read, mem_write_en, words_done, mem_access_addr, mem_write_data and all internal registers SHALL be 0.
REQ-034 Assertion of rst_n mid-transfer SHALL immediately deassert mem_write_en and mem_read and abort without a done pulse; the first accepted start after release SHALL behave as from power-up.

Verification
REQ-035 Copy: memory[0..2]={0x1111,0x2222,0x3333}, start mode=0 src=0 dst=4 len=3 -> memory[4..6]={0x1111,0x2222,0x3333}, done pulses once 7 cycles after start edge, words_done=3.
REQ-036 Fill: start mode=1 dst=2 len=4 fill_data=0xA5A5 -> memory[2..5]=0xA5A5, exactly 4 write strobes, done 5 cycles after start edge.
REQ-037 len=0: start mode=0 -> no mem_read/mem_write_en pulses, done 1 cycle later, words_done=0.
REQ-038 Overlap/wrap: memory[0]=0x0001, copy src=0 dst=1 len=3 -> memory[1..3]=0x0001; copy dst=0xFFFF len=2 -> writes at 0xFFFF then 0x0000.
REQ-039 Busy ignore: start re-asserted every cycle during a len=3 copy -> single transfer, single done pulse, then new transfer accepted only from IDLE.
REQ-040 Reset mid-transfer: rst_n=0 during second WRITE of len=4 copy -> mem_write_en drops same cycle, no done pulse, only first word written; subsequent len=1 copy completes normally.
